multi_counter_controller: RTL and testbench
===========================================

// Module: multi_counter_controller
// PURPOSE
//  Parametrised N-channel counter controller. Each channel runs an independent
//  Idle/IrqStart/Calc/IrqDone handshake FSM with its own integrated up-counter,
//  programmable limit, abort, auto-reload and optional start-IRQ bypass. It sits
//  behind the AXI counter IP register file, and the host acks each interrupt.
// PARAMETERS
//  NUM_CH  4   number of independent channels (1..16)
//  CNT_W   32  counter and limit width per channel (2..32)
// PORTS
//  clk         in   1             single clock; every flop on its rising edge
//  rst         in   1             asynchronous, active-high reset
//  start       in   NUM_CH        per-channel start request; used only in IDLE
//  abort       in   NUM_CH        per-channel abort; used in any non-IDLE state
//  ack         in   NUM_CH        per-channel interrupt acknowledge
//  mode_reload in   NUM_CH        1: restart automatically after the done ack
//  skip_start  in   NUM_CH        1: bypass IRQ_START; go straight to CALC
//  limit       in   NUM_CH*CNT_W  terminal count; ch i = limit[i*CNT_W +: CNT_W]
//  count       out  NUM_CH*CNT_W  live counter value, packed the same way
//  busy        out  NUM_CH        channel state != IDLE
//  irq_start   out  NUM_CH        channel is in IRQ_START
//  irq_done    out  NUM_CH        channel is in IRQ_DONE
//  irq         out  1             OR of all irq_start and irq_done bits
// BEHAVIOUR
//  - Reset (async, any cycle, mid-run included): all channels go to IDLE, the
//    counter and latched limit/mode go to 0, and every output is 0.
//  - Channel outputs are Moore outputs decoded from the state register; no
//    combinational path runs from any input to any output.
//  - IDLE: count is held at 0.
//    If start=1, latch limit into lim_q and latch mode_reload and skip_start.
//    Next state is IRQ_START, or CALC when skip_start=1.
//  - IRQ_START: irq_start=1. ack=1 -> CALC. Otherwise hold.
//  - CALC: count increments by 1 each cycle. In the cycle where count==lim_q
//    the counter holds and next state is IRQ_DONE.
//    Result: CALC lasts lim_q+1 cycles. With limit=0, the first CALC cycle
//    moves to IRQ_DONE.
//  - IRQ_DONE: irq_done=1 and count holds at lim_q. When ack=1:
//      reload=0 -> IDLE.
//      reload=1 -> count clears to 0 and the FSM re-enters IRQ_START (CALC if
//      skip_start) using the already-latched lim_q. No new start is needed.
//  - abort=1 in any non-IDLE state -> IDLE next cycle with count cleared.
//    No IRQ is raised for an aborted run. abort in IDLE is ignored.
//  - Priority inside a channel: abort > ack > count compare.
//  - start outside IDLE is ignored. ack in IDLE or CALC is ignored (not stored).
//  - Changing limit, mode_reload or skip_start mid-run has no effect until the
//    next start from IDLE.
//  - Width: count <= lim_q <= 2^CNT_W-1, so the counter never wraps.
//  - Channels are fully independent, and any subset may be active in the same
//    cycle.
// STRUCTURE
//  - Package counter_ctrl_pkg holds the state encoding:
//    ST_IDLE=0, ST_IRQ_START=1, ST_CALC=2, ST_IRQ_DONE=3, 2 bits wide.
//  - Sub-module counter_channel: one FSM, one CNT_W counter, lim_q and the mode
//    flops. It is instantiated NUM_CH times by a generate loop.
//  - The top level does the bus slicing and the irq OR reduction.
// TESTING
//  1. CNT_W=8, ch0 limit=5, start pulse, skip=0: irq_start[0] the cycle after
//     start. Ack -> count runs 0..5 over 6 CALC cycles, then irq_done[0]=1 with
//     count=5. Ack -> IDLE, count=0, busy=0.
//  2. ch1 limit=0, skip_start=1: start -> CALC for 1 cycle -> irq_done[1].
//     irq=1 until ack.
//  3. ch2 reload=1, limit=3: after the done ack, irq_start[2] reasserts with no
//     new start. Three full cycles run and irq stays 0 during CALC.
//  4. Abort: abort ch3 at count=2 in CALC -> IDLE next cycle, count=0, no
//     irq_done. Same abort+ack in IRQ_DONE -> IDLE.
//  5. Concurrency: all 4 channels started together with limits 1/2/3/4.
//     Done IRQs appear in order, irq stays 1 while any is pending, and each
//     ack clears only its own channel.
//  6. Assert rst while ch0 is in CALC at count=7: all outputs 0 immediately
//     (async). After release, ch0 is IDLE and ignores a stale ack.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared state encoding for the per-channel counter handshake FSM.
package counter_ctrl_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 2'd0,
      ST_IRQ_START = 2'd1,
      ST_CALC      = 2'd2,
      ST_IRQ_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/counter_channel.sv
// One counter channel: start/done interrupt handshake FSM, up-counter,
// latched limit and latched reload/skip mode bits.
module counter_channel
   import counter_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             ack,
   input  logic             mode_reload,
   input  logic             skip_start,
   input  logic [CNT_W-1:0] limit,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             irq_start,
   output logic             irq_done
);

   state_t           state;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] lim_q;
   logic             reload_q;
   logic             skip_q;

   // Abort beats ack, ack beats the terminal-count compare.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt_q    <= '0;
         lim_q    <= '0;
         reload_q <= 1'b0;
         skip_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt_q <= '0;
               if (start) begin
                  lim_q    <= limit;
                  reload_q <= mode_reload;
                  skip_q   <= skip_start;
                  state    <= skip_start ? ST_CALC : ST_IRQ_START;
               end
            end
            ST_IRQ_START: begin
               if (abort) begin
                  state <= ST_IDLE;
                  cnt_q <= '0;
               end else if (ack) begin
                  state <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (abort) begin
                  state <= ST_IDLE;
                  cnt_q <= '0;
               end else if (cnt_q == lim_q) begin
                  state <= ST_IRQ_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_IRQ_DONE: begin
               if (abort) begin
                  state <= ST_IDLE;
                  cnt_q <= '0;
               end else if (ack) begin
                  cnt_q <= '0;
                  if (!reload_q) begin
                     state <= ST_IDLE;
                  end else begin
                     state <= skip_q ? ST_CALC : ST_IRQ_START;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt_q <= '0;
            end
         endcase
      end
   end

   // Moore outputs decoded straight from the state register.
   assign count     = cnt_q;
   assign busy      = (state != ST_IDLE);
   assign irq_start = (state == ST_IRQ_START);
   assign irq_done  = (state == ST_IRQ_DONE);

endmodule

// File: rtl/multi_counter_controller.sv
// N independent counter channels behind one register file, with a combined
// interrupt line.
module multi_counter_controller
   import counter_ctrl_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       start,
   input  logic [NUM_CH-1:0]       abort,
   input  logic [NUM_CH-1:0]       ack,
   input  logic [NUM_CH-1:0]       mode_reload,
   input  logic [NUM_CH-1:0]       skip_start,
   input  logic [NUM_CH*CNT_W-1:0] limit,
   output logic [NUM_CH*CNT_W-1:0] count,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH-1:0]       irq_start,
   output logic [NUM_CH-1:0]       irq_done,
   output logic                    irq
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      counter_channel #(
         .CNT_W(CNT_W)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .start      (start[i]),
         .abort      (abort[i]),
         .ack        (ack[i]),
         .mode_reload(mode_reload[i]),
         .skip_start (skip_start[i]),
         .limit      (limit[i*CNT_W +: CNT_W]),
         .count      (count[i*CNT_W +: CNT_W]),
         .busy       (busy[i]),
         .irq_start  (irq_start[i]),
         .irq_done   (irq_done[i])
      );
   end

   // Reduction of flop-decoded bits only; no input reaches irq.
   assign irq = |{irq_start, irq_done};

endmodule

// File: tb/tb_multi_counter_controller.sv
// Bench for multi_counter_controller: directed scenarios plus random traffic
// checked against a flag-based channel model.
module tb_multi_counter_controller;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned CNT_W  = 8;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_CH-1:0]       start, abort, ack, mode_reload, skip_start;
   logic [CNT_W-1:0]        lim_in [NUM_CH];
   logic [NUM_CH*CNT_W-1:0] limit;
   logic [NUM_CH*CNT_W-1:0] count;
   logic [NUM_CH-1:0]       busy, irq_start, irq_done;
   logic                    irq;

   // Reference model: a run is active, waiting on a start ack, counting,
   // or waiting on a done ack.
   logic             m_busy [NUM_CH];
   logic             m_ps   [NUM_CH];
   logic             m_calc [NUM_CH];
   logic             m_pd   [NUM_CH];
   logic [CNT_W-1:0] m_cnt  [NUM_CH];
   logic [CNT_W-1:0] m_lim  [NUM_CH];
   logic             m_rel  [NUM_CH];
   logic             m_skip [NUM_CH];

   logic [NUM_CH*CNT_W-1:0] exp_count;
   logic [NUM_CH-1:0]       exp_busy, exp_ps, exp_pd;
   logic                    exp_irq;

   int n_checks = 0;
   int n_errors = 0;

   multi_counter_controller #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .ack(ack),
      .mode_reload(mode_reload), .skip_start(skip_start), .limit(limit),
      .count(count), .busy(busy), .irq_start(irq_start), .irq_done(irq_done),
      .irq(irq)
   );

   always #5 clk = ~clk;

   always_comb begin
      limit     = '0;
      exp_count = '0;
      exp_busy  = '0;
      exp_ps    = '0;
      exp_pd    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         limit[i*CNT_W +: CNT_W]     = lim_in[i];
         exp_count[i*CNT_W +: CNT_W] = m_cnt[i];
         exp_busy[i] = m_busy[i];
         exp_ps[i]   = m_ps[i];
         exp_pd[i]   = m_pd[i];
      end
      exp_irq = |{exp_ps, exp_pd};
   end

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_busy[i] = 0; m_ps[i] = 0; m_calc[i] = 0; m_pd[i] = 0;
         m_cnt[i] = '0; m_lim[i] = '0; m_rel[i] = 0; m_skip[i] = 0;
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < NUM_CH; i++) begin
         if (!m_busy[i]) begin
            if (start[i]) begin
               m_busy[i] = 1; m_lim[i] = lim_in[i];
               m_rel[i] = mode_reload[i]; m_skip[i] = skip_start[i];
               m_ps[i] = !skip_start[i]; m_calc[i] = skip_start[i];
               m_cnt[i] = '0;
            end
         end else if (abort[i]) begin
            m_busy[i] = 0; m_ps[i] = 0; m_calc[i] = 0; m_pd[i] = 0;
            m_cnt[i] = '0;
         end else if (m_ps[i]) begin
            if (ack[i]) begin m_ps[i] = 0; m_calc[i] = 1; end
         end else if (m_calc[i]) begin
            if (m_cnt[i] == m_lim[i]) begin m_calc[i] = 0; m_pd[i] = 1; end
            else m_cnt[i] = m_cnt[i] + 1'b1;
         end else if (m_pd[i] && ack[i]) begin
            m_pd[i] = 0; m_cnt[i] = '0;
            if (m_rel[i]) begin m_ps[i] = !m_skip[i]; m_calc[i] = m_skip[i]; end
            else m_busy[i] = 0;
         end
      end
   endtask

   // Advance one clock: model sees the same inputs the DUT samples.
   task automatic tick();
      @(posedge clk);
      if (!rst) model_step();
      #1;
   endtask

   task automatic clear_inputs();
      start = '0; abort = '0; ack = '0; mode_reload = '0; skip_start = '0;
      for (int i = 0; i < NUM_CH; i++) lim_in[i] = '0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      model_reset();
      repeat (3) tick();
      n_checks++;
      if ({count, busy, irq_start, irq_done, irq} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: got count=%h busy=%b irq_start=%b irq_done=%b irq=%b, want all 0",
                  count, busy, irq_start, irq_done, irq);
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (busy !== '0 || count !== '0) begin
         n_errors++;
         $display("FAIL reset_release: got busy=%b count=%h, want 0", busy, count);
      end
   endtask

   task automatic test_single_run();
      lim_in[0] = 8'd5; start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      n_checks++;
      if (irq_start !== 4'b0001 || busy !== 4'b0001 || irq !== 1'b1) begin
         n_errors++;
         $display("FAIL single_irq_start: got irq_start=%b busy=%b irq=%b, want 0001/0001/1",
                  irq_start, busy, irq);
      end
      ack[0] = 1'b1;
      tick();
      ack[0] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         n_checks++;
         if (count[7:0] !== 8'(k) || irq !== 1'b0 || irq_done[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL single_calc%0d: got count=%0d irq=%b irq_done=%b, want %0d/0/0",
                     k, count[7:0], irq, irq_done[0], k);
         end
         tick();
      end
      n_checks++;
      if (irq_done !== 4'b0001 || count[7:0] !== 8'd5) begin
         n_errors++;
         $display("FAIL single_done: got irq_done=%b count=%0d, want 0001/5", irq_done, count[7:0]);
      end
      ack[0] = 1'b1;
      tick();
      ack[0] = 1'b0;
      n_checks++;
      if (busy !== 4'b0000 || count !== '0 || irq !== 1'b0) begin
         n_errors++;
         $display("FAIL single_idle: got busy=%b count=%h irq=%b, want 0", busy, count, irq);
      end
   endtask

   task automatic test_skip_zero_limit();
      lim_in[1] = 8'd0; skip_start[1] = 1'b1; start[1] = 1'b1;
      tick();
      start[1] = 1'b0; skip_start[1] = 1'b0;
      n_checks++;
      if (busy !== 4'b0010 || irq !== 1'b0 || irq_start !== '0) begin
         n_errors++;
         $display("FAIL skip_calc: got busy=%b irq=%b irq_start=%b, want 0010/0/0000", busy, irq, irq_start);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (irq_done !== 4'b0010 || irq !== 1'b1) begin
            n_errors++;
            $display("FAIL skip_done_hold%0d: got irq_done=%b irq=%b, want 0010/1", k, irq_done, irq);
         end
         tick();
      end
      ack[1] = 1'b1;
      tick();
      ack[1] = 1'b0;
      n_checks++;
      if (busy !== '0 || irq !== 1'b0) begin
         n_errors++;
         $display("FAIL skip_idle: got busy=%b irq=%b, want 0/0", busy, irq);
      end
   endtask

   task automatic test_reload();
      lim_in[2] = 8'd3; mode_reload[2] = 1'b1; start[2] = 1'b1;
      tick();
      start[2] = 1'b0; mode_reload[2] = 1'b0; lim_in[2] = 8'd9;
      for (int r = 0; r < 3; r++) begin
         n_checks++;
         if (irq_start !== 4'b0100) begin
            n_errors++;
            $display("FAIL reload_start%0d: got irq_start=%b, want 0100", r, irq_start);
         end
         ack[2] = 1'b1;
         tick();
         ack[2] = 1'b0;
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (irq !== 1'b0 || count[23:16] !== 8'(k)) begin
               n_errors++;
               $display("FAIL reload_calc%0d_%0d: got irq=%b count=%0d, want 0/%0d", r, k, irq, count[23:16], k);
            end
            tick();
         end
         n_checks++;
         if (irq_done !== 4'b0100 || count[23:16] !== 8'd3) begin
            n_errors++;
            $display("FAIL reload_done%0d: got irq_done=%b count=%0d, want 0100/3", r, irq_done, count[23:16]);
         end
         ack[2] = 1'b1;
         tick();
         ack[2] = 1'b0;
      end
      abort[2] = 1'b1;
      tick();
      abort[2] = 1'b0;
      n_checks++;
      if (busy !== '0 || irq !== 1'b0) begin
         n_errors++;
         $display("FAIL reload_abort: got busy=%b irq=%b, want 0/0", busy, irq);
      end
   endtask

   task automatic test_abort();
      lim_in[3] = 8'd10; skip_start[3] = 1'b1; start[3] = 1'b1;
      tick();
      start[3] = 1'b0;
      repeat (2) tick();
      n_checks++;
      if (count[31:24] !== 8'd2) begin
         n_errors++;
         $display("FAIL abort_precount: got count=%0d, want 2", count[31:24]);
      end
      abort[3] = 1'b1;
      tick();
      abort[3] = 1'b0;
      n_checks++;
      if (busy !== '0 || count !== '0 || irq_done !== '0) begin
         n_errors++;
         $display("FAIL abort_calc: got busy=%b count=%h irq_done=%b, want 0", busy, count, irq_done);
      end
      lim_in[3] = 8'd1; start[3] = 1'b1;
      tick();
      start[3] = 1'b0;
      repeat (2) tick();
      n_checks++;
      if (irq_done !== 4'b1000) begin
         n_errors++;
         $display("FAIL abort_reach_done: got irq_done=%b, want 1000", irq_done);
      end
      abort[3] = 1'b1; ack[3] = 1'b1; mode_reload[3] = 1'b1;
      tick();
      abort[3] = 1'b0; ack[3] = 1'b0; mode_reload[3] = 1'b0;
      n_checks++;
      if (busy !== '0 || irq !== 1'b0) begin
         n_errors++;
         $display("FAIL abort_done: got busy=%b irq=%b, want 0/0", busy, irq);
      end
      skip_start[3] = 1'b0; abort[3] = 1'b1; start[3] = 1'b1;
      tick();
      abort[3] = 1'b0; start[3] = 1'b0;
      n_checks++;
      if (irq_start !== 4'b1000) begin
         n_errors++;
         $display("FAIL abort_idle_ignored: got irq_start=%b, want 1000", irq_start);
      end
      abort[3] = 1'b1;
      tick();
      abort[3] = 1'b0;
   endtask

   task automatic test_concurrent();
      int first_done [NUM_CH];
      logic [NUM_CH-1:0] want;
      for (int i = 0; i < NUM_CH; i++) begin
         lim_in[i] = 8'(i + 1); first_done[i] = -1;
      end
      skip_start = '1; start = '1;
      tick();
      start = '0; skip_start = '0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         for (int i = 0; i < NUM_CH; i++)
            if (irq_done[i] && first_done[i] < 0) first_done[i] = c;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         n_checks++;
         if (first_done[i] != i + 2) begin
            n_errors++;
            $display("FAIL conc_done_order ch%0d: got cycle %0d, want %0d", i, first_done[i], i + 2);
         end
      end
      want = 4'b1111;
      for (int i = 0; i < NUM_CH; i++) begin
         ack = 4'(1 << i);
         tick();
         ack = '0;
         want[i] = 1'b0;
         n_checks++;
         if (irq_done !== want || irq !== (want != 0)) begin
            n_errors++;
            $display("FAIL conc_ack ch%0d: got irq_done=%b irq=%b, want %b/%b", i, irq_done, irq, want, want != 0);
         end
      end
   endtask

   task automatic test_async_reset();
      lim_in[0] = 8'd20; skip_start[0] = 1'b1; start[0] = 1'b1;
      tick();
      start[0] = 1'b0; skip_start[0] = 1'b0;
      repeat (7) tick();
      n_checks++;
      if (count[7:0] !== 8'd7) begin
         n_errors++;
         $display("FAIL async_precount: got %0d, want 7", count[7:0]);
      end
      #2 rst = 1'b1;
      #1;
      model_reset();
      n_checks++;
      if ({count, busy, irq_start, irq_done, irq} !== '0) begin
         n_errors++;
         $display("FAIL async_reset: got count=%h busy=%b irq=%b, want 0", count, busy, irq);
      end
      tick();
      rst = 1'b0;
      ack[0] = 1'b1;
      tick();
      ack[0] = 1'b0;
      tick();
      n_checks++;
      if (busy !== '0 || irq !== 1'b0 || count !== '0) begin
         n_errors++;
         $display("FAIL async_stale_ack: got busy=%b irq=%b count=%h, want 0", busy, irq, count);
      end
   endtask

   task automatic test_random();
      int bad = 0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            start[i]       = ($urandom_range(0, 3) == 0);
            ack[i]         = ($urandom_range(0, 2) == 0);
            abort[i]       = ($urandom_range(0, 24) == 0);
            mode_reload[i] = ($urandom_range(0, 3) == 0);
            skip_start[i]  = ($urandom_range(0, 1) == 0);
            lim_in[i]      = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 7));
         end
         tick();
         n_checks++;
         if (count !== exp_count || busy !== exp_busy || irq_start !== exp_ps ||
             irq_done !== exp_pd || irq !== exp_irq) begin
            n_errors++;
            if (bad < 10)
               $display("FAIL random_cycle%0d: got count=%h busy=%b ps=%b pd=%b irq=%b, want %h/%b/%b/%b/%b",
                        c, count, busy, irq_start, irq_done, irq,
                        exp_count, exp_busy, exp_ps, exp_pd, exp_irq);
            bad++;
         end
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_single_run();
      test_skip_zero_limit();
      test_reload();
      test_abort();
      test_concurrent();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
